// File: rtl/card_dealer.sv
// card_dealer
// Deal stage that closes the loop with the next-address stage. It owns the
// current deck address, takes the candidate address produced downstream,
// skips already-dealt cards by linear probing, marks the chosen card used and
// presents rank, suit and blackjack value for one cycle on card_valid.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   new_deck    synchronous deck refill; aborts any deal in flight
//   deal_req    request one card (accepted only in IDLE with cards left)
//   nxt_addr    candidate address from the next-address stage (0..63)
//   cur_addr    address of the last dealt card, feeds the next-address stage
//   busy        high in SEEK, PROBE and OUT
//   card_valid  one-cycle strobe, card outputs are new this cycle
//   card_rank   1..13 (1 = ace, 11..13 = J, Q, K)
//   card_suit   0..3
//   card_value  blackjack value, face cards count 10, ace reported as 1
//   cards_left  undealt cards, 0..DECK_SIZE
//   deck_empty  cards_left == 0
//
// state | meaning
// IDLE  | waiting for deal_req with cards left
// SEEK  | load probe from the candidate address, folded into 0..DECK_SIZE-1
// PROBE | walk forward past used slots, take the first free one
// OUT   | card_valid strobe, outputs hold the new card

module card_dealer #(
  parameter int DECK_SIZE = 52,
  parameter int RANKS     = 13
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       new_deck,
  input  logic       deal_req,
  input  logic [5:0] nxt_addr,
  output logic [5:0] cur_addr,
  output logic       busy,
  output logic       card_valid,
  output logic [3:0] card_rank,
  output logic [1:0] card_suit,
  output logic [3:0] card_value,
  output logic [5:0] cards_left,
  output logic       deck_empty
);

  localparam logic [5:0] DECK = 6'(DECK_SIZE);
  localparam logic [5:0] LAST = 6'(DECK_SIZE - 1);
  localparam logic [5:0] R1   = 6'(RANKS);
  localparam logic [5:0] R2   = 6'(2 * RANKS);
  localparam logic [5:0] R3   = 6'(3 * RANKS);

  typedef enum logic [1:0] {IDLE, SEEK, PROBE, OUT} state_t;

  state_t               state;
  state_t               state_nxt;
  logic [DECK_SIZE-1:0] used;
  logic [5:0]           probe;
  logic [5:0]           seek_addr;
  logic [5:0]           probe_inc;
  logic                 take;

  logic [1:0]           suit_c;
  logic [5:0]           rank_off;
  logic [3:0]           rank_c;
  logic [3:0]           value_c;

  // candidate is at most 63, so one subtraction folds it into the deck
  assign seek_addr  = (nxt_addr >= DECK) ? nxt_addr - DECK : nxt_addr;
  assign probe_inc  = (probe == LAST) ? 6'd0 : probe + 6'd1;
  assign deck_empty = (cards_left == 6'd0);

  // suit and rank by threshold compare instead of a divider
  always_comb begin
    suit_c   = 2'd0;
    rank_off = probe;
    if (probe >= R3) begin
      suit_c   = 2'd3;
      rank_off = probe - R3;
    end else if (probe >= R2) begin
      suit_c   = 2'd2;
      rank_off = probe - R2;
    end else if (probe >= R1) begin
      suit_c   = 2'd1;
      rank_off = probe - R1;
    end
    rank_c  = 4'(rank_off + 6'd1);
    value_c = (rank_c > 4'd10) ? 4'd10 : rank_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    take       = 1'b0;
    busy       = (state != IDLE);
    card_valid = (state == OUT);
    case (state)
      IDLE:  if (deal_req && !deck_empty) state_nxt = SEEK;
      SEEK:  state_nxt = PROBE;
      PROBE: begin
        if (!used[probe]) begin
          take      = 1'b1;
          state_nxt = OUT;
        end
      end
      OUT:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // refill wins over everything, including a probe that would have hit
    if (new_deck) begin
      state_nxt = IDLE;
      take      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      used       <= '0;
      probe      <= 6'd0;
      cur_addr   <= 6'd0;
      cards_left <= DECK;
      card_rank  <= 4'd0;
      card_suit  <= 2'd0;
      card_value <= 4'd0;
    end else if (new_deck) begin
      // cur_addr and the card outputs are kept so the address loop keeps
      // its history across decks
      used       <= '0;
      cards_left <= DECK;
    end else if (state == SEEK) begin
      probe <= seek_addr;
    end else if (state == PROBE) begin
      if (take) begin
        used[probe] <= 1'b1;
        cur_addr    <= probe;
        cards_left  <= cards_left - 6'd1;
        card_rank   <= rank_c;
        card_suit   <= suit_c;
        card_value  <= value_c;
      end else begin
        probe <= probe_inc;
      end
    end
  end

endmodule

// File: tb/tb_card_dealer.sv
module tb_card_dealer;

  logic       clk = 1'b0;
  logic       rst;
  logic       new_deck;
  logic       deal_req;
  logic [5:0] nxt_addr;
  logic [5:0] cur_addr;
  logic       busy;
  logic       card_valid;
  logic [3:0] card_rank;
  logic [1:0] card_suit;
  logic [3:0] card_value;
  logic [5:0] cards_left;
  logic       deck_empty;

  card_dealer dut (
    .clk        (clk),
    .rst        (rst),
    .new_deck   (new_deck),
    .deal_req   (deal_req),
    .nxt_addr   (nxt_addr),
    .cur_addr   (cur_addr),
    .busy       (busy),
    .card_valid (card_valid),
    .card_rank  (card_rank),
    .card_suit  (card_suit),
    .card_value (card_value),
    .cards_left (cards_left),
    .deck_empty (deck_empty)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // reference model: a deck as a set of used cards plus a count
  bit m_used[52];
  int m_left;
  int m_last;

  // observations from the last do_deal
  int         o_lat;
  logic [5:0] o_addr;
  logic [5:0] o_left;
  logic [3:0] o_rank;
  logic [1:0] o_suit;
  logic [3:0] o_val;

  function automatic int e_rank(int a); return a % 13 + 1; endfunction
  function automatic int e_suit(int a); return a / 13; endfunction
  function automatic int e_val(int a);
    return (e_rank(a) > 10) ? 10 : e_rank(a);
  endfunction

  task automatic m_reset();
    foreach (m_used[i]) m_used[i] = 1'b0;
    m_left = 52;
  endtask

  task automatic m_pick(input int cand, output int addr, output int skips);
    int p;
    p = (cand >= 52) ? cand - 52 : cand;
    skips = 0;
    while (m_used[p]) begin
      p = (p + 1) % 52;
      skips++;
    end
    m_used[p] = 1'b1;
    m_left--;
    m_last = p;
    addr = p;
  endtask

  // one deal request; latency counted in cycles with the accept cycle as 0
  task automatic do_deal(input logic [5:0] cand);
    int n;
    o_lat = -1;
    @(negedge clk);
    nxt_addr = cand;
    deal_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    deal_req = 1'b0;
    n = 0;
    @(posedge clk);
    #1;
    n = 1;
    while (n < 70 && !card_valid) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (card_valid) begin
      o_lat  = n + 1;
      o_addr = cur_addr;
      o_left = cards_left;
      o_rank = card_rank;
      o_suit = card_suit;
      o_val  = card_value;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_new_deck();
    @(negedge clk);
    new_deck = 1'b1;
    @(negedge clk);
    new_deck = 1'b0;
    m_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1; new_deck = 1'b0; deal_req = 1'b0; nxt_addr = 6'd0;
    m_reset();
    m_last = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (cur_addr !== 6'd0 || busy !== 1'b0 || card_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got cur_addr=%0d busy=%b valid=%b, want 0 0 0",
               cur_addr, busy, card_valid);
    end
    checks++;
    if (card_rank !== 4'd0 || card_suit !== 2'd0 || card_value !== 4'd0) begin
      fails++;
      $display("FAIL reset_card: got rank=%0d suit=%0d value=%0d, want 0 0 0",
               card_rank, card_suit, card_value);
    end
    checks++;
    if (cards_left !== 6'd52 || deck_empty !== 1'b0) begin
      fails++;
      $display("FAIL reset_count: got left=%0d empty=%b, want 52 0", cards_left, deck_empty);
    end
  endtask

  task automatic test_first_deal();
    int a, s;
    do_deal(6'd0);
    m_pick(0, a, s);
    checks++;
    if (o_lat !== 3 || o_addr !== 6'(a) || o_rank !== 4'(e_rank(a)) || o_suit !== 2'(e_suit(a))
        || o_val !== 4'(e_val(a)) || o_left !== 6'(m_left)) begin
      fails++;
      $display("FAIL first_deal: got lat=%0d addr=%0d rank=%0d suit=%0d value=%0d left=%0d, want %0d %0d %0d %0d %0d %0d",
               o_lat, o_addr, o_rank, o_suit, o_val, o_left, 3, a, e_rank(a), e_suit(a), e_val(a), m_left);
    end
  endtask

  task automatic test_probe_skip();
    int a, s;
    int cands[2] = '{24, 24};
    pulse_new_deck();
    foreach (cands[k]) begin
      do_deal(6'(cands[k]));
      m_pick(cands[k], a, s);
      checks++;
      if (o_lat !== 3 + s || o_addr !== 6'(a) || o_rank !== 4'(e_rank(a)) || o_suit !== 2'(e_suit(a))
          || o_val !== 4'(e_val(a)) || o_left !== 6'(m_left)) begin
        fails++;
        $display("FAIL probe_skip[%0d]: got lat=%0d addr=%0d rank=%0d suit=%0d value=%0d left=%0d, want %0d %0d %0d %0d %0d %0d",
                 k, o_lat, o_addr, o_rank, o_suit, o_val, o_left, 3 + s, a, e_rank(a), e_suit(a), e_val(a), m_left);
      end
    end
  endtask

  task automatic test_reset_mid_deal();
    @(negedge clk);
    nxt_addr = 6'd30;
    deal_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    deal_req = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || card_valid !== 1'b0 || cards_left !== 6'd52 || cur_addr !== 6'd0) begin
      fails++;
      $display("FAIL reset_mid_deal: got busy=%b valid=%b left=%0d cur_addr=%0d, want 0 0 52 0",
               busy, card_valid, cards_left, cur_addr);
    end
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    m_last = 0;
  endtask

  task automatic test_wrap();
    int a, s;
    int cands[4] = '{50, 51, 51, 63};
    pulse_new_deck();
    foreach (cands[k]) begin
      do_deal(6'(cands[k]));
      m_pick(cands[k], a, s);
      checks++;
      if (o_lat !== 3 + s || o_addr !== 6'(a) || o_rank !== 4'(e_rank(a)) || o_suit !== 2'(e_suit(a))
          || o_val !== 4'(e_val(a)) || o_left !== 6'(m_left)) begin
        fails++;
        $display("FAIL wrap[%0d]: got lat=%0d addr=%0d rank=%0d suit=%0d value=%0d left=%0d, want %0d %0d %0d %0d %0d %0d",
                 k, o_lat, o_addr, o_rank, o_suit, o_val, o_left, 3 + s, a, e_rank(a), e_suit(a), e_val(a), m_left);
      end
    end
  endtask

  task automatic test_full_deck();
    int a, s, cand, distinct, bad;
    bit seen[52];
    pulse_new_deck();
    foreach (seen[i]) seen[i] = 1'b0;
    bad = 0;
    for (int k = 0; k < 52; k++) begin
      // next-address stage model: last address plus a free-running count
      cand = (m_last + $urandom_range(0, 63)) % 64;
      do_deal(6'(cand));
      m_pick(cand, a, s);
      if (o_lat >= 0 && o_addr < 6'd52) seen[o_addr] = 1'b1;
      checks++;
      if (o_lat !== 3 + s || o_addr !== 6'(a) || o_rank !== 4'(e_rank(a)) || o_suit !== 2'(e_suit(a))
          || o_val !== 4'(e_val(a)) || o_left !== 6'(m_left)) begin
        fails++;
        bad++;
        if (bad < 5)
          $display("FAIL full_deck[%0d] cand=%0d: got lat=%0d addr=%0d rank=%0d suit=%0d value=%0d left=%0d, want %0d %0d %0d %0d %0d %0d",
                   k, cand, o_lat, o_addr, o_rank, o_suit, o_val, o_left, 3 + s, a, e_rank(a), e_suit(a), e_val(a), m_left);
      end
    end
    distinct = 0;
    foreach (seen[i]) distinct += int'(seen[i]);
    checks++;
    if (distinct !== 52) begin
      fails++;
      $display("FAIL full_deck_distinct: got %0d distinct addresses, want 52", distinct);
    end
    checks++;
    if (cards_left !== 6'd0 || deck_empty !== 1'b1) begin
      fails++;
      $display("FAIL full_deck_empty: got left=%0d empty=%b, want 0 1", cards_left, deck_empty);
    end
    // request on an empty deck must be ignored
    bad = 0;
    @(negedge clk);
    deal_req = 1'b1;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (busy || card_valid) bad++;
    end
    deal_req = 1'b0;
    checks++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL empty_deal_ignored: got %0d busy/valid cycles, want 0", bad);
    end
  endtask

  task automatic test_new_deck_abort();
    int a, s, bad;
    pulse_new_deck();
    for (int k = 0; k < 10; k++) begin
      do_deal(6'd0);
      m_pick(0, a, s);
    end
    checks++;
    if (o_lat !== 12 || o_addr !== 6'd9 || o_left !== 6'd42) begin
      fails++;
      $display("FAIL preload_tenth: got lat=%0d addr=%0d left=%0d, want 12 9 42", o_lat, o_addr, o_left);
    end
    // start an eleventh deal that must probe past ten used slots
    @(negedge clk);
    nxt_addr = 6'd0;
    deal_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    deal_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    new_deck = 1'b1;
    @(negedge clk);
    new_deck = 1'b0;
    m_reset();
    bad = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (busy || card_valid) bad++;
    end
    checks++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL abort_no_card: got %0d busy/valid cycles, want 0", bad);
    end
    checks++;
    if (cards_left !== 6'd52 || deck_empty !== 1'b0) begin
      fails++;
      $display("FAIL abort_refill: got left=%0d empty=%b, want 52 0", cards_left, deck_empty);
    end
    // same-cycle new_deck and deal_req: the request is dropped
    @(negedge clk);
    new_deck = 1'b1;
    deal_req = 1'b1;
    @(negedge clk);
    new_deck = 1'b0;
    deal_req = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL new_deck_wins: got busy=%b, want 0", busy);
    end
    do_deal(6'd7);
    m_pick(7, a, s);
    checks++;
    if (o_lat !== 3 + s || o_addr !== 6'(a) || o_rank !== 4'(e_rank(a)) || o_suit !== 2'(e_suit(a))
        || o_val !== 4'(e_val(a)) || o_left !== 6'(m_left)) begin
      fails++;
      $display("FAIL after_abort: got lat=%0d addr=%0d rank=%0d suit=%0d value=%0d left=%0d, want %0d %0d %0d %0d %0d %0d",
               o_lat, o_addr, o_rank, o_suit, o_val, o_left, 3 + s, a, e_rank(a), e_suit(a), e_val(a), m_left);
    end
  endtask

  task automatic test_back_to_back();
    int a, s, cand, pulses, cyc, last_cyc, bad;
    int exp_gap;
    pulse_new_deck();
    cand = $urandom_range(0, 63);
    pulses = 0; cyc = 0; last_cyc = 0; bad = 0; exp_gap = 0;
    @(negedge clk);
    nxt_addr = 6'(cand);
    deal_req = 1'b1;
    repeat (60) begin
      @(posedge clk);
      #1;
      cyc++;
      if (card_valid) begin
        m_pick(cand, a, s);
        // first card: accept edge plus 2; later cards: 4 cycles per deal plus skips
        exp_gap = (pulses == 0) ? 3 + s : 4 + s;
        pulses++;
        checks++;
        if (cyc - last_cyc !== exp_gap || cur_addr !== 6'(a) || card_rank !== 4'(e_rank(a))
            || card_suit !== 2'(e_suit(a)) || cards_left !== 6'(m_left)) begin
          fails++;
          $display("FAIL held_req[%0d]: got gap=%0d addr=%0d rank=%0d suit=%0d left=%0d, want %0d %0d %0d %0d %0d",
                   pulses, cyc - last_cyc, cur_addr, card_rank, card_suit, cards_left,
                   exp_gap, a, e_rank(a), e_suit(a), m_left);
        end
        last_cyc = cyc;
        if (pulses == 3) deal_req = 1'b0;
      end
    end
    checks++;
    if (pulses !== 3) begin
      fails++;
      $display("FAIL held_req_count: got %0d cards, want 3", pulses);
    end
    // random extra request pulses while busy must not produce extra cards
    pulses = 0;
    @(negedge clk);
    nxt_addr = 6'($urandom_range(0, 63));
    deal_req = 1'b1;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (card_valid) pulses++;
      deal_req = busy ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    deal_req = 1'b0;
    checks++;
    if (pulses !== 1) begin
      fails++;
      $display("FAIL busy_req_ignored: got %0d cards, want 1", pulses);
    end
  endtask

  initial begin
    test_reset();
    test_first_deal();
    test_probe_skip();
    test_reset_mid_deal();
    test_wrap();
    test_full_deck();
    test_new_deck_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
